amci_arbiter: RTL and testbench

- Shares one AMCI single-beat AXI master (its amci_write/amci_read user interface) between NUM_REQ independent requesters.
- Each requester posts one read or write at a time; the arbiter grants round-robin, drives the master's AMCI strobes and returns data/response to the winner.
- Sits directly above the AXI master in the same clock domain; the arbiter is the master's sole driver.

---
 rtl/amci_arb_pkg.sv | 21 ++
 rtl/amci_rr_picker.sv | 45 ++++
 rtl/amci_arbiter.sv | 145 ++++++++++++++
 tb/tb_amci_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amci_arb_pkg.sv
// amci_arb_pkg: shared types and constants for the AMCI requester arbiter.
// Optional build macro AMCI_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package amci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/amci_rr_picker.sv
// amci_rr_picker: combinational winner selection among pending requesters.
// Default: first valid at or after ptr, wrapping. With AMCI_ARB_FIXED_PRIO_EN:
// lowest index wins and there is no ptr input.
module amci_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
`ifndef AMCI_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  assign any = |valid;

`ifdef AMCI_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[k]) pick = IDX_W'(k);
    end
  end
`else
  int   j;
  logic found;

  // Walk the valid vector starting at ptr and take the first set entry.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/amci_arbiter.sv
// amci_arbiter: shares one single-beat AMCI AXI master among NUM_REQ requesters.
// One transaction outstanding; round-robin grant by default, fixed priority
// (lowest index) when AMCI_ARB_FIXED_PRIO_EN is defined.
module amci_arbiter
  import amci_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 34,
  parameter int AXI_DATA_WIDTH = 512
) (
  input  logic                                M_AXI_ACLK,
  input  logic                                M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]           amci_waddr,
  output logic [AXI_DATA_WIDTH-1:0]           amci_wdata,
  output logic                                amci_write,
  input  logic                                amci_widle,
  input  logic [1:0]                          amci_wresp,
  output logic [AXI_ADDR_WIDTH-1:0]           amci_raddr,
  output logic                                amci_read,
  input  logic                                amci_ridle,
  input  logic [AXI_DATA_WIDTH-1:0]           amci_rdata,
  input  logic [1:0]                          amci_rresp
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   pick, gnt_idx;
  logic               any_valid, gnt_write;
  logic               do_grant, do_done;
  int                 pick_i;

  assign pick_i = int'(pick);

`ifdef AMCI_ARB_FIXED_PRIO_EN
  amci_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .valid (req_valid),
    .pick  (pick),
    .any   (any_valid)
  );
`else
  logic [IDX_W-1:0] rr_ptr;

  amci_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .pick  (pick),
    .any   (any_valid)
  );

  // Advance the round-robin pointer past the requester that just completed.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) rr_ptr <= '0;
    else if (do_done)   rr_ptr <= IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
  end
`endif

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next state: grant only when the master is fully idle; complete when the
  // active direction reports idle again and no strobe is still in flight.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && amci_widle && amci_ridle) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!amci_write && !amci_read && (gnt_write ? amci_widle : amci_ridle)) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant datapath: latch the winner, raise its accept pulse and the matching
  // master strobe for exactly one cycle; address/data hold between transactions.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      gnt_idx    <= '0;
      gnt_write  <= 1'b0;
      req_ready  <= '0;
      amci_write <= 1'b0;
      amci_read  <= 1'b0;
      amci_waddr <= '0;
      amci_wdata <= '0;
      amci_raddr <= '0;
    end else begin
      req_ready  <= '0;
      amci_write <= 1'b0;
      amci_read  <= 1'b0;
      if (do_grant) begin
        gnt_idx   <= pick;
        gnt_write <= req_write[pick];
        req_ready <= NUM_REQ'(1) << pick;
        if (req_write[pick]) begin
          amci_write <= 1'b1;
          amci_waddr <= req_addr[pick_i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          amci_wdata <= req_wdata[pick_i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end else begin
          amci_read  <= 1'b1;
          amci_raddr <= req_addr[pick_i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        end
      end
    end
  end

  // Response datapath: capture the master's response and pulse the winner's
  // completion; writes leave the shared read-data bus untouched.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rsp_valid <= '0;
      rsp_resp  <= RESP_OKAY;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (do_done) begin
        rsp_valid <= NUM_REQ'(1) << gnt_idx;
        rsp_resp  <= gnt_write ? amci_wresp : amci_rresp;
        if (!gnt_write) rsp_rdata <= amci_rdata;
      end
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// tb_amci_arbiter: scoreboard bench for amci_arbiter. Stimulus pushes expected
// grants/responses into queues; a negedge monitor pops and compares them.
// Expectations follow AMCI_ARB_FIXED_PRIO_EN when the macro is defined.
module tb_amci_arbiter;
  import amci_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 34;
  localparam int DW = 512;

  typedef struct {
    int             idx;
    bit             write;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
  } gnt_t;

  typedef struct {
    int             idx;
    bit             write;
    logic [DW-1:0]  rdata;
    logic [1:0]     resp;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [AW-1:0]    amci_waddr, amci_raddr;
  logic [DW-1:0]    amci_wdata, amci_rdata;
  logic             amci_write, amci_read, amci_widle, amci_ridle;
  logic [1:0]       amci_wresp, amci_rresp;

  gnt_t gq[$];
  rsp_t rq[$];

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  int gnt_seen = 0, rsp_seen = 0, hold_viol = 0, b2b_rsps = 0;
  int last_rsp_cycle = -100;
  bit b2b_mode = 1'b0;
  logic [DW-1:0] model_rdata = '0;

  logic [AW-1:0] r_addr[NR];
  logic [DW-1:0] r_wdata[NR];
  bit            r_write[NR];
  int            r_target[NR];
  int            r_issued[NR];

  int            m_lat;
  bit            w_hold;
  bit            m_widle, m_ridle;
  int            wcnt, rcnt;
  logic [1:0]    m_wresp, m_rresp;
  logic [DW-1:0] m_rdata;

  amci_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .amci_waddr    (amci_waddr),
    .amci_wdata    (amci_wdata),
    .amci_write    (amci_write),
    .amci_widle    (amci_widle),
    .amci_wresp    (amci_wresp),
    .amci_raddr    (amci_raddr),
    .amci_read     (amci_read),
    .amci_ridle    (amci_ridle),
    .amci_rdata    (amci_rdata),
    .amci_rresp    (amci_rresp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Requester bus assembled from the per-requester tables.
  always_comb begin
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (r_issued[i] < r_target[i]);
      req_write[i] = r_write[i];
      req_addr[i*AW +: AW] = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  end

  assign amci_widle = m_widle & ~w_hold;
  assign amci_ridle = m_ridle;
  assign amci_wresp = m_wresp;
  assign amci_rresp = m_rresp;
  assign amci_rdata = m_rdata;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oneHotIdx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Requesters: a pending request retires once its accept pulse is seen.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rst_n && req_ready[i]) begin
        checkOutput("valid_held", req_valid[i], 1'b1);
        r_issued[i]++;
      end
    end
  end

  // Master model: goes busy when it sees a strobe, idles again after m_lat cycles.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_widle = 1'b1; m_ridle = 1'b1; wcnt = 0; rcnt = 0;
    end else begin
      if (amci_write) begin
        m_widle = 1'b0; wcnt = m_lat;
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) m_widle = 1'b1;
      end
      if (amci_read) begin
        m_ridle = 1'b0; rcnt = m_lat;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) m_ridle = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a grant or response is presented.
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    int   gi;
    if (!rst_n) begin
      model_rdata = '0;
    end else begin
      if (req_ready != '0 || amci_write || amci_read) begin
        gnt_seen++;
        if (w_hold) hold_viol++;
        checkOutput("ready_onehot", $onehot(req_ready), 1'b1);
        if (gq.size() == 0) begin
          checkOutput("unexpected_grant", gq.size(), 1);
        end else begin
          g  = gq.pop_front();
          gi = oneHotIdx(req_ready);
          checkOutput("grant_idx", gi, g.idx);
          checkOutput("strobe_write", amci_write, g.write);
          checkOutput("strobe_read", amci_read, !g.write);
          if (g.write) begin
            checkOutput("waddr", amci_waddr, g.addr);
            checkOutput("wdata", amci_wdata, g.wdata);
          end else begin
            checkOutput("raddr", amci_raddr, g.addr);
          end
          if (b2b_mode && b2b_rsps > 0)
            checkOutput("b2b_gap_ok", (cycle - last_rsp_cycle) <= 1, 1'b1);
        end
      end
      if (rsp_valid != '0) begin
        rsp_seen++;
        if (b2b_mode) b2b_rsps++;
        last_rsp_cycle = cycle;
        checkOutput("rsp_onehot", $onehot(rsp_valid), 1'b1);
        if (rq.size() == 0) begin
          checkOutput("unexpected_rsp", rq.size(), 1);
        end else begin
          r = rq.pop_front();
          checkOutput("rsp_idx", oneHotIdx(rsp_valid), r.idx);
          checkOutput("rsp_resp", rsp_resp, r.resp);
          if (!r.write) model_rdata = r.rdata;
          checkOutput("rsp_rdata", rsp_rdata, model_rdata);
        end
      end
    end
  end

  task automatic setRequester(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_write[i] = wr;
    r_addr[i]  = a;
    r_wdata[i] = d;
  endtask

  task automatic expectTxn(input int i, input logic [DW-1:0] rdata, input logic [1:0] resp);
    gnt_t g;
    rsp_t r;
    g.idx = i; g.write = r_write[i]; g.addr = r_addr[i]; g.wdata = r_wdata[i];
    r.idx = i; r.write = r_write[i]; r.rdata = rdata; r.resp = resp;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  task automatic applyStimulus(input int i, input int n);
    r_target[i] += n;
  endtask

  task automatic waitRsp(input int n);
    int budget = 0;
    while (rsp_seen < n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("rsp_count", rsp_seen, n);
  endtask

  task automatic waitGrant(input int n);
    int budget = 0;
    while (gnt_seen < n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("grant_count", gnt_seen, n);
  endtask

  initial begin
    int ord[8];
    int s, g0, hv;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      r_target[i] = 0; r_issued[i] = 0;
      setRequester(i, 1'b0, '0, '0);
    end
    m_lat = 3; w_hold = 1'b0;
    m_wresp = RESP_OKAY; m_rresp = RESP_OKAY; m_rdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_amci_write", amci_write, 0);
    checkOutput("rst_amci_read", amci_read, 0);
    checkOutput("rst_rsp_resp", rsp_resp, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesters pending, two writes each.
    $display("[TB] rotation");
`ifdef AMCI_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int i = 0; i < NR; i++) setRequester(i, 1'b1, AW'(32'h1000 + i * 16), DW'(32'h5500 + i));
    m_wresp = RESP_EXOKAY;
    for (int k = 0; k < 8; k++) expectTxn(ord[k], '0, RESP_EXOKAY);
    for (int i = 0; i < NR; i++) applyStimulus(i, 2);
    waitRsp(8);

    // Requester 2 write.
    $display("[TB] single write");
    setRequester(2, 1'b1, AW'(34'h100), DW'(32'hA5));
    m_wresp = RESP_OKAY;
    expectTxn(2, '0, RESP_OKAY);
    applyStimulus(2, 1);
    waitRsp(9);

    // Requester 1 read with a slave error.
    $display("[TB] single read");
    setRequester(1, 1'b0, AW'(34'h40), '0);
    m_rdata = DW'(32'hDEADBEEF); m_rresp = RESP_SLVERR;
    expectTxn(1, DW'(32'hDEADBEEF), RESP_SLVERR);
    applyStimulus(1, 1);
    waitRsp(10);

    // Write side busy for 20 cycles: nothing may be granted.
    $display("[TB] idle hold");
    w_hold = 1'b1;
    setRequester(0, 1'b1, AW'(34'h200), DW'(32'h77));
    m_wresp = RESP_OKAY;
    expectTxn(0, '0, RESP_OKAY);
    g0 = gnt_seen; hv = hold_viol;
    applyStimulus(0, 1);
    repeat (20) @(negedge clk);
    checkOutput("hold_no_grant", gnt_seen, g0);
    checkOutput("hold_no_strobe", hold_viol, hv);
    w_hold = 1'b0;
    waitRsp(11);

    // Requester 0 back-to-back writes.
    $display("[TB] back to back");
    setRequester(0, 1'b1, AW'(34'h300), DW'(32'hB0B));
    b2b_mode = 1'b1;
    for (int k = 0; k < 5; k++) expectTxn(0, '0, RESP_OKAY);
    applyStimulus(0, 5);
    waitRsp(16);
    b2b_mode = 1'b0;
    checkOutput("b2b_rsp_pulses", b2b_rsps, 5);

    // Reset while requester 3's read is outstanding.
    $display("[TB] reset mid read");
    setRequester(3, 1'b0, AW'(34'h3C0), '0);
    m_lat = 10; m_rdata = DW'(32'h1234); m_rresp = RESP_OKAY;
    expectTxn(3, DW'(32'h1234), RESP_OKAY);
    g0 = gnt_seen;
    applyStimulus(3, 1);
    waitGrant(g0 + 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_req_ready", req_ready, 0);
    checkOutput("arst_rsp_valid", rsp_valid, 0);
    checkOutput("arst_amci_read", amci_read, 0);
    checkOutput("arst_amci_write", amci_write, 0);
    checkOutput("arst_rsp_resp", rsp_resp, 0);
    checkOutput("arst_rsp_rdata", rsp_rdata, 0);
    rq.delete();
    s = rsp_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lat = 3;
    repeat (15) @(negedge clk);
    checkOutput("no_rsp_after_reset", rsp_seen, s);

    // After reset the pointer is back at 0: requester 0 beats requester 3.
    setRequester(0, 1'b1, AW'(34'h400), DW'(32'hC0DE));
    m_wresp = RESP_DECERR; m_rresp = RESP_EXOKAY;
    expectTxn(0, '0, RESP_DECERR);
    expectTxn(3, DW'(32'h1234), RESP_EXOKAY);
    applyStimulus(0, 1);
    applyStimulus(3, 1);
    waitRsp(s + 2);

    checkOutput("grant_queue_empty", gq.size(), 0);
    checkOutput("rsp_queue_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
